// File: rtl/pwm_pkg.sv
// Shared types for the PWM ramp controller: FSM states, step direction and
// the ramp command record presented by a command source.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH       = 8;
  localparam int unsigned PWM_DWELL_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STEP   = 3'd1,
    ST_DWELL  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } pwm_ramp_state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_t;

  typedef struct packed {
    logic [PWM_WIDTH-1:0]       period;
    logic [PWM_WIDTH-1:0]       duty;
    logic [PWM_WIDTH-1:0]       step;
    logic [PWM_DWELL_WIDTH-1:0] dwell;
  } pwm_ramp_cmd_t;

endpackage

// File: rtl/pwm_duty_step.sv
// Saturating duty stepper: moves current toward target by step without
// wrapping and without passing the target.
module pwm_duty_step
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] current_i,
  input  logic [WIDTH-1:0] target_i,
  input  logic [WIDTH-1:0] step_i,
  output logic [WIDTH-1:0] next_o
);

  pwm_dir_t     dir_s;
  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;

  // One extra bit catches carry out on the way up and borrow on the way down.
  always_comb begin
    dir_s  = (target_i >= current_i) ? DIR_UP : DIR_DOWN;
    sum_s  = {1'b0, current_i} + {1'b0, step_i};
    diff_s = {1'b0, current_i} - {1'b0, step_i};
    next_o = target_i;
    case (dir_s)
      DIR_UP: begin
        if (sum_s < {1'b0, target_i}) begin
          next_o = sum_s[WIDTH-1:0];
        end else begin
          next_o = target_i;
        end
      end
      DIR_DOWN: begin
        if (!diff_s[WIDTH] && (diff_s > {1'b0, target_i})) begin
          next_o = diff_s[WIDTH-1:0];
        end else begin
          next_o = target_i;
        end
      end
      default: next_o = target_i;
    endcase
  end

endmodule

// File: rtl/pwm_ramp_controller.sv
// Ramp sequencer for a PWM generator: accepts ramp commands and strobes new
// period/duty values, holding each step for a number of PWM periods.
module pwm_ramp_controller
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned INITIAL_PERIOD = 255,
  parameter int unsigned INITIAL_DUTY   = 0,
  parameter int unsigned DWELL_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [WIDTH-1:0]       cmd_period,
  input  logic [WIDTH-1:0]       cmd_duty,
  input  logic [WIDTH-1:0]       cmd_step,
  input  logic [DWELL_WIDTH-1:0] cmd_dwell,
  input  logic                   abort,
  input  logic                   period_end,
  output logic                   update_parameters,
  output logic [WIDTH-1:0]       pwm_period,
  output logic [WIDTH-1:0]       pwm_duty_cycle,
  output logic                   busy,
  output logic                   done
);

  localparam logic [WIDTH-1:0] INIT_PERIOD_C = WIDTH'(INITIAL_PERIOD);
  localparam logic [WIDTH-1:0] INIT_DUTY_C   = WIDTH'(INITIAL_DUTY);

  pwm_ramp_state_t        state_q, state_d;
  logic [WIDTH-1:0]       period_q, period_d;
  logic [WIDTH-1:0]       duty_q, duty_d;
  logic                   upd_q, upd_d;
  logic                   done_q, done_d;
  logic [WIDTH-1:0]       target_q, target_d;
  logic [WIDTH-1:0]       step_q, step_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] acc_target_s, acc_step_s, acc_base_s;
  logic [WIDTH-1:0] cur_s, tgt_s, stp_s, next_s;

  // Accept-cycle operands come straight from the command; later steps use the latched ramp.
  always_comb begin
    acc_target_s = (cmd_duty > cmd_period) ? cmd_period : cmd_duty;
    acc_step_s   = (cmd_step == {WIDTH{1'b0}}) ? cmd_period : cmd_step;
    acc_base_s   = (duty_q > cmd_period) ? cmd_period : duty_q;
    if (state_q == ST_IDLE) begin
      cur_s = acc_base_s;
      tgt_s = acc_target_s;
      stp_s = acc_step_s;
    end else begin
      cur_s = duty_q;
      tgt_s = target_q;
      stp_s = step_q;
    end
  end

  pwm_duty_step #(.WIDTH(WIDTH)) u_step (
    .current_i (cur_s),
    .target_i  (tgt_s),
    .step_i    (stp_s),
    .next_o    (next_s)
  );

  // Next-state logic; the output registers are loaded on entry to STEP so the strobe is registered.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    duty_d   = duty_q;
    upd_d    = 1'b0;
    done_d   = 1'b0;
    target_d = target_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          target_d = acc_target_s;
          step_d   = acc_step_s;
          dwell_d  = cmd_dwell;
          if ((cmd_period == period_q) && (acc_base_s == acc_target_s)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_STEP;
            period_d = cmd_period;
            duty_d   = next_s;
            upd_d    = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (duty_q == target_q) begin
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_DWELL;
          cnt_d   = {DWELL_WIDTH{1'b0}};
        end
      end
      ST_DWELL: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (period_end) begin
          if (cnt_q == dwell_q) begin
            state_d = ST_STEP;
            duty_d  = next_s;
            upd_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + DWELL_WIDTH'(1'b1);
          end
        end else begin
          state_d = ST_DWELL;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (period_end) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      period_q <= INIT_PERIOD_C;
      duty_q   <= INIT_DUTY_C;
      upd_q    <= 1'b0;
      done_q   <= 1'b0;
      target_q <= {WIDTH{1'b0}};
      step_q   <= {WIDTH{1'b0}};
      dwell_q  <= {DWELL_WIDTH{1'b0}};
      cnt_q    <= {DWELL_WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      upd_q    <= upd_d;
      done_q   <= done_d;
      target_q <= target_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cmd_ready         = (state_q == ST_IDLE);
  assign busy              = (state_q != ST_IDLE);
  assign update_parameters = upd_q;
  assign done              = done_q;
  assign pwm_period        = period_q;
  assign pwm_duty_cycle    = duty_q;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Bench for pwm_ramp_controller: a behavioural PWM generator supplies period_end,
// a ramp-list model predicts every output each cycle, directed tests pin the model.
`timescale 1ns/1ps
module tb_pwm_ramp_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_period = 8'd0, cmd_duty = 8'd0, cmd_step = 8'd0, cmd_dwell = 8'd0;
  logic       abort = 1'b0;
  logic       period_end;
  logic       update_parameters;
  logic [7:0] pwm_period, pwm_duty_cycle;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_ramp_controller #(
    .WIDTH(8), .INITIAL_PERIOD(8), .INITIAL_DUTY(0), .DWELL_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_period(cmd_period), .cmd_duty(cmd_duty), .cmd_step(cmd_step),
    .cmd_dwell(cmd_dwell), .abort(abort), .period_end(period_end),
    .update_parameters(update_parameters), .pwm_period(pwm_period),
    .pwm_duty_cycle(pwm_duty_cycle), .busy(busy), .done(done)
  );

  // Standalone 4-bit stepper for the exhaustive sweep.
  logic [3:0] s4_cur, s4_tgt, s4_stp, s4_next;
  pwm_duty_step #(.WIDTH(4)) u_step4 (
    .current_i(s4_cur), .target_i(s4_tgt), .step_i(s4_stp), .next_o(s4_next)
  );

  // Behavioural PWM generator: counts 0..period, pulses period_end at the top.
  logic [7:0] gen_period, gen_duty, gen_cnt;
  assign period_end = (gen_cnt >= gen_period);
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      gen_cnt <= 8'd0; gen_period <= 8'd8; gen_duty <= 8'd0;
    end else begin
      gen_cnt <= period_end ? 8'd0 : gen_cnt + 8'd1;
      if (update_parameters) begin
        gen_period <= pwm_period;
        gen_duty   <= pwm_duty_cycle;
      end
    end
  end

  // Model: on accept the whole duty list is computed, then consumed one entry per dwell.
  int m_phase;  // 0 idle, 1 strobe cycle, 2 waiting pulses, 3 settling, 4 done cycle
  int m_period, m_duty, m_upd, m_done, m_left, m_dwell;
  int m_q[$];
  always @(posedge clk or posedge reset) begin : mdl
    int p, t, s, b, cur;
    if (reset) begin
      m_phase = 0; m_period = 8; m_duty = 0; m_upd = 0; m_done = 0; m_q.delete();
    end else begin
      m_upd = 0; m_done = 0;
      case (m_phase)
        0: if (cmd_valid) begin
             p = int'(cmd_period);
             t = (int'(cmd_duty) > p) ? p : int'(cmd_duty);
             s = (cmd_step == 8'd0) ? p : int'(cmd_step);
             b = (m_duty > p) ? p : m_duty;
             m_dwell = int'(cmd_dwell);
             if (p == m_period && b == t) begin
               m_done = 1; m_phase = 4;
             end else begin
               m_q.delete(); cur = b;
               do begin
                 if (cur < t) cur = (cur + s > t) ? t : cur + s;
                 else if (cur > t) cur = (cur - s < t) ? t : cur - s;
                 m_q.push_back(cur);
               end while (cur != t);
               m_period = p; m_duty = m_q.pop_front(); m_upd = 1; m_phase = 1;
             end
           end
        1: if (abort) m_phase = 0;
           else if (m_q.size() == 0) m_phase = 3;
           else begin m_phase = 2; m_left = m_dwell + 1; end
        2: if (abort) m_phase = 0;
           else if (period_end) begin
             m_left--;
             if (m_left == 0) begin m_duty = m_q.pop_front(); m_upd = 1; m_phase = 1; end
           end
        3: if (abort) m_phase = 0;
           else if (period_end) begin m_done = 1; m_phase = 4; end
        4: m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (pwm_period !== 8'(m_period) || pwm_duty_cycle !== 8'(m_duty) ||
          update_parameters !== (m_upd != 0) || done !== (m_done != 0) ||
          busy !== (m_phase != 0) || cmd_ready !== (m_phase == 0)) begin
        errors++;
        $display("FAIL model_cmp t=%0t act per=%0d duty=%0d upd=%0b done=%0b busy=%0b rdy=%0b exp per=%0d duty=%0d upd=%0d done=%0d phase=%0d",
                 $time, pwm_period, pwm_duty_cycle, update_parameters, done, busy, cmd_ready,
                 m_period, m_duty, m_upd, m_done, m_phase);
      end
    end
  end

  // Strobe / done log used by the literal checks.
  int  log_duty[$], log_per[$], log_pes[$];
  time log_t[$];
  int  pes = 0, done_cnt = 0;
  time done_t = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (update_parameters) begin
        log_duty.push_back(int'(pwm_duty_cycle)); log_per.push_back(int'(pwm_period));
        log_pes.push_back(pes); log_t.push_back($time); pes = 0;
      end else if (period_end) begin
        pes++;
      end
      if (done) begin done_cnt++; done_t = $time; end
    end
  end

  time acc_time;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clear_log();
    log_duty.delete(); log_per.delete(); log_pes.delete(); log_t.delete();
  endtask

  task automatic send(input int p, input int d, input int s, input int dw);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_period = p[7:0]; cmd_duty = d[7:0];
    cmd_step = s[7:0]; cmd_dwell = dw[7:0];
    while (!cmd_ready && n < 200) begin tick(); n++; end
    chk("accept_timeout", int'(cmd_ready), 1);
    @(posedge clk); acc_time = $time;
    tick(); cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin tick(); n++; end
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic wait_strobes(input int cnt, input int budget);
    int n;
    n = 0;
    while (log_duty.size() < cnt && n < budget) begin tick(); n++; end
    chk("strobe_timeout", log_duty.size(), cnt);
  endtask

  initial begin : main
    int exp4, hi, n, d0;

    // Exhaustive 4-bit stepper sweep.
    for (int c = 0; c < 16; c++)
      for (int t = 0; t < 16; t++)
        for (int s = 0; s < 16; s++) begin
          s4_cur = c[3:0]; s4_tgt = t[3:0]; s4_stp = s[3:0];
          #1;
          if (c < t) exp4 = (c + s > t) ? t : c + s;
          else if (c > t) exp4 = (c - s < t) ? t : c - s;
          else exp4 = t;
          checks++;
          if (int'(s4_next) != exp4) begin
            errors++;
            $display("FAIL step4 cur=%0d tgt=%0d stp=%0d actual=%0d expected=%0d", c, t, s, s4_next, exp4);
          end
        end

    // 1: reset then hold.
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("rst_period", int'(pwm_period), 8);
    chk("rst_duty", int'(pwm_duty_cycle), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_no_strobe", log_duty.size(), 0);

    // 2: ramp up 0 -> 4 by 1, one period per step.
    clear_log();
    send(8, 4, 1, 0);
    wait_idle(200);
    chk("up_count", log_duty.size(), 4);
    if (log_duty.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("up_duty", log_duty[i], i + 1);
      for (int i = 1; i < 4; i++) chk("up_pes", log_pes[i], 1);
      chk("up_first_latency", int'(log_t[0] - acc_time), 5);
    end
    n = 0;
    while (!period_end && n < 40) begin tick(); n++; end
    hi = 0;
    for (int i = 0; i < 9; i++) begin tick(); if (gen_cnt < gen_duty) hi++; end
    chk("dutycnt_high", hi, 4);
    chk("dutycnt_period", int'(gen_period), 8);

    // 3: jump to 7, then ramp down to 2 by 3 with dwell 1.
    send(8, 7, 0, 0);
    wait_idle(100);
    chk("pre_down_duty", int'(pwm_duty_cycle), 7);
    clear_log();
    send(8, 2, 3, 1);
    wait_idle(200);
    chk("down_count", log_duty.size(), 2);
    if (log_duty.size() == 2) begin
      chk("down_duty0", log_duty[0], 4);
      chk("down_duty1", log_duty[1], 2);
      chk("down_pes", log_pes[1], 2);
    end

    // 4: clamp target to period and jump with step 0.
    clear_log();
    send(16, 20, 0, 0);
    wait_idle(100);
    chk("clamp_count", log_duty.size(), 1);
    if (log_duty.size() == 1) begin
      chk("clamp_period", log_per[0], 16);
      chk("clamp_duty", log_duty[0], 16);
    end

    // 5: abort during dwell, then resume from the held duty.
    send(8, 0, 0, 0);
    wait_idle(100);
    clear_log();
    d0 = done_cnt;
    send(8, 8, 1, 3);
    wait_strobes(2, 200);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_duty", int'(pwm_duty_cycle), 2);
    repeat (20) tick();
    chk("abort_no_done", done_cnt, d0);
    chk("abort_no_more_strobes", log_duty.size(), 2);
    clear_log();
    send(8, 4, 1, 0);
    wait_idle(200);
    chk("resume_count", log_duty.size(), 2);
    if (log_duty.size() == 2) begin
      chk("resume_duty0", log_duty[0], 3);
      chk("resume_duty1", log_duty[1], 4);
    end

    // 6a: command equal to current state completes without strobes.
    clear_log();
    d0 = done_cnt;
    send(8, 4, 2, 0);
    chk("noop_done_cnt", done_cnt, d0 + 1);
    chk("noop_done_latency", int'(done_t - acc_time), 5);
    wait_idle(10);
    chk("noop_no_strobe", log_duty.size(), 0);

    // 6b: asynchronous reset mid-ramp.
    clear_log();
    send(8, 0, 1, 0);
    wait_strobes(1, 50);
    tick();
    #1 reset = 1'b1;
    #1;
    chk("arst_period", int'(pwm_period), 8);
    chk("arst_duty", int'(pwm_duty_cycle), 0);
    chk("arst_upd", int'(update_parameters), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_ready", int'(cmd_ready), 1);
    chk("arst_done", int'(done), 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("post_rst_duty", int'(pwm_duty_cycle), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_controller.md
Name: pwm_ramp_controller

Overview:
- Sequencer that programs a PWMGenerator instance through its update_parameters / pwm_period / pwm_duty_cycle inputs.
- Accepts ramp commands over a valid/ready handshake and steps the duty cycle toward a target, a fixed amount at a time.
- Each step is held for a programmable number of PWM periods, counted from the generator's period_end pulse.
- Used for soft-start, LED fades and motor ramps; sits between a register/command source and one PWMGenerator.

Parameters:
- WIDTH, 8, width of period/duty values; matches the generator's WIDTH.
- INITIAL_PERIOD, 255, pwm_period value driven out of reset.
- INITIAL_DUTY, 0, pwm_duty_cycle value driven out of reset; must be <= INITIAL_PERIOD.
- DWELL_WIDTH, 8, width of the dwell count.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command (high only in IDLE).
- cmd_period  in  WIDTH  period for the ramp.
- cmd_duty  in  WIDTH  target duty; clamped to cmd_period.
- cmd_step  in  WIDTH  duty change per step; 0 means jump straight to target.
- cmd_dwell  in  DWELL_WIDTH  extra periods per step; each step is held for cmd_dwell+1 period_end pulses.
- abort  in  1  stop the ramp, hold current outputs.
- period_end  in  1  from the generator; one-cycle pulse per PWM period.
- update_parameters  out  1  one-cycle load strobe to the generator.
- pwm_period  out  WIDTH  registered period to the generator.
- pwm_duty_cycle  out  WIDTH  registered duty to the generator.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the ramp completes.

Behaviour:
- Reset (async, immediate, also mid-ramp): state IDLE, pwm_period=INITIAL_PERIOD, pwm_duty_cycle=INITIAL_DUTY, update_parameters=0, busy=0, done=0, cmd_ready=1, dwell counter=0.
- Outputs are registered; pwm_period/pwm_duty_cycle change only in the cycle where update_parameters=1, otherwise held.
- States: IDLE, STEP, DWELL, SETTLE, DONE.
- IDLE:
  - Accept on cmd_valid&&cmd_ready (cycle 0); latch period P, target T=min(cmd_duty,P), step S (S=0 treated as S=P), dwell D.
  - Base duty B=min(current duty,P).
  - If P==current period and B==T: go to DONE.
  - Otherwise go to STEP.
  - abort is ignored in IDLE, including in the accept cycle.
- STEP (single cycle):
  - update_parameters=1, pwm_period=P, pwm_duty_cycle=next.
  - next = B+S saturated at T when ramping up, B-S saturated at T when ramping down.
  - Arithmetic in WIDTH+1 bits: no wrap, no overshoot/undershoot.
  - If next==T go to SETTLE, else go to DWELL with counter cleared.
  - First update is therefore visible in cycle 1 after accept.
- DWELL:
  - Count period_end pulses; a pulse coincident with a STEP strobe cycle is counted in DWELL only if the state is DWELL.
  - On the (D+1)-th pulse go to STEP; the next update is visible the cycle after that pulse.
- SETTLE: wait for one period_end (final value has taken effect), then go to DONE.
- DONE: done=1 for one cycle, busy=1; next state IDLE (cmd_ready high the following cycle).
- abort in STEP/DWELL/SETTLE/DONE:
  - Next state IDLE, outputs hold last written values, no done pulse.
  - An update strobe being driven in that cycle still completes.
- cmd_valid while busy: not accepted, no side effect; the source must hold cmd_valid until cmd_ready.

Decomposition:
- Package pwm_pkg:
  - state enum pwm_ramp_state_t.
  - struct pwm_ramp_cmd_t {period, duty, step, dwell}, parameterised by the WIDTH/DWELL_WIDTH localparam defaults.
  - direction enum UP/DOWN.
- One sub-module pwm_duty_step: purely combinational saturating step, (current, target, step) -> next.
  - Unit-tested standalone with exhaustive WIDTH=4 sweep.

Test Plan:
1. Reset, then hold (INITIAL_PERIOD=8, INITIAL_DUTY=0). Required: pwm_period=8, pwm_duty_cycle=0, cmd_ready=1, busy=0, no update strobes for 20 cycles.
2. Ramp up, with a real PWMGenerator and DutyCounter attached. Command P=8,T=4,S=1,D=0. Required:
   - Strobes with duty 1,2,3,4, the first in cycle 1, each later one the cycle after a period_end.
   - done one period_end after the duty=4 strobe.
   - DutyCounter reads 4/8 afterwards.
3. Ramp down with non-divisible step. From duty 7, P=8, command T=2,S=3,D=1. Required: duty sequence 4 then 2, with two period_ends between strobes; never below 2.
4. Clamp and jump. Command P=16, cmd_duty=20, S=0. Required: single strobe with period 16, duty 16, then done after the next period_end.
5. Abort mid-DWELL. Ramp 0->8 (P=8,S=1,D=3); assert abort after the duty=2 strobe. Required:
   - Duty stays 2, no done, busy=0 next cycle, cmd_ready=1.
   - A new command then resumes from base 2.
6. No-op command and reset mid-ramp.
   - Command equal to current state: done in cycle 1, zero strobes.
   - Reset asserted mid-ramp: outputs return to INITIAL values immediately, without waiting for a clock edge.
